// File: rtl/logic_unit_acc_if.sv
// Handshake bundle for logic_unit_acc: input beat channel, result channel and busy flag.
// The master drives beats and result acceptance; the slave is the logic unit itself.
interface logic_unit_acc_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_last;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  modport master (
    output in_valid, in_op, in_last, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_count, busy
  );

  modport slave (
    input  in_valid, in_op, in_last, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_count, busy
  );
endinterface

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit with valid/ready handshake and a burst mode that
// folds several beats into one result using AND, OR or XOR reduction.
module logic_unit_acc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  logic_unit_acc_if.slave lu
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             accept;
  logic             isReduce;
  logic [2:0]       effOp;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] foldRes;
  logic [CNT_W-1:0] cntInc;

  function automatic logic [WIDTH-1:0] plainOp(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a & b);
      default: return ~a;
    endcase
  endfunction

  // The low two op bits select the same operator for both the beat term and the fold.
  function automatic logic [WIDTH-1:0] reduceOp(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (sel)
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  assign accept   = lu.in_valid && lu.in_ready;
  assign isReduce = lu.in_op[2] && (lu.in_op[1:0] != 2'b00);
  assign effOp    = (state_q == ACCUM) ? op_q : lu.in_op;
  assign term     = reduceOp(effOp[1:0], lu.in_a, lu.in_b);
  assign foldRes  = reduceOp(op_q[1:0], acc_q, term);
  assign cntInc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  assign lu.in_ready  = !out_valid_q || lu.out_ready;
  assign lu.out_valid = out_valid_q;
  assign lu.out_data  = out_data_q;
  assign lu.out_count = out_count_q;
  assign lu.busy      = (state_q == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && isReduce && !lu.in_last) state_d = ACCUM;
      ACCUM:   if (accept && lu.in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A freshly produced result overrides the acceptance-driven clear of out_valid.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    out_valid_d = out_valid_q && !lu.out_ready;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (accept) begin
      if (state_q == ACCUM) begin
        if (lu.in_last) begin
          out_valid_d = 1'b1;
          out_data_d  = foldRes;
          out_count_d = cntInc;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = foldRes;
          cnt_d = cntInc;
        end
      end else if (!isReduce) begin
        out_valid_d = 1'b1;
        out_data_d  = plainOp(lu.in_op, lu.in_a, lu.in_b);
        out_count_d = CNT_ONE;
      end else if (lu.in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = term;
        out_count_d = CNT_ONE;
      end else begin
        acc_d = term;
        cnt_d = CNT_ONE;
        op_d  = lu.in_op;
      end
    end
  end

endmodule

// File: doc/logic_unit_acc.md
Name: logic_unit_acc

Overview:
- Parametrised, registered bitwise logic unit. Successor to the fixed 16-bit combinational AND gate.
- Generalised in data width and operation set. Adds a valid/ready handshake and a burst-reduction mode that folds multiple beats into one result.
- Sits between the register file and the ALU writeback path. Feeds flag/mask logic in the CPU datapath.

Parameters:
- WIDTH, 16, data width of a, b and out_data (>=1).
- CNT_W, 8, width of the burst beat counter (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_op  input  3  operation select (see Behaviour).
- in_last  input  1  final beat of a reduction burst; ignored for plain ops.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  result.
- out_count  output  CNT_W  number of beats folded into out_data.
- busy  output  1  reduction burst in progress (state ACCUM).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_count=0, busy=0, accumulator=0, latched op=0, state=IDLE. Takes effect immediately and mid-burst; partial burst is discarded with no output.
- Beat accepted when in_valid && in_ready. Result accepted when out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational, for every beat type. No combinational path from in_* to out_*.
- Plain ops (in state IDLE), per beat f(a,b):
  - 000 AND a&b
  - 001 OR a|b
  - 010 XOR a^b
  - 011 NAND ~(a&b)
  - 100 NOT ~a (b ignored)
- Plain ops: latency 1. Accepted at edge N gives out_valid=1 with out_data=f, out_count=1 after edge N.
- Reduction ops: 101 AND-reduce, 110 OR-reduce, 111 XOR-reduce. Per-beat term t = a&b, a|b, a^b respectively.
- Fold operator R: AND for 101, OR for 110, XOR for 111.
- State machine IDLE / ACCUM:
  - IDLE, accept reduction op with in_last=0: acc=t, cnt=1, op latched, go ACCUM, busy=1. No output.
  - IDLE, accept reduction op with in_last=1: single-beat burst. Output out_data=t, out_count=1, stay IDLE.
  - ACCUM, accept beat with in_last=0: acc=acc R t, cnt=cnt+1 (saturating at 2^CNT_W-1). No output.
  - ACCUM, accept beat with in_last=1: out_data=acc R t, out_count=cnt+1 (saturating), out_valid=1, go IDLE, busy=0.
- During ACCUM, in_op is ignored; the latched op applies to all beats. A plain-op encoding mid-burst is treated as a burst beat.
- Output register holds out_data/out_count stable while out_valid && !out_ready.
- Output is cleared to out_valid=0 on acceptance unless a new result-producing beat is accepted the same cycle.
- Simultaneous result accept + new result beat: back-to-back throughput of 1 result/cycle, no bubble.
- Non-final reduction beats are accepted under the same in_ready rule. They never alter the output register.
- Count saturation: out_count sticks at max. Data folding continues correctly past saturation.

Test Plan:
- Reset then plain ops, WIDTH=16: a=0x00F3 b=0x00FF op=000 -> out 0x00F3, count 1. op=011 -> 0xFF0C. op=100 a=0x1234 -> 0xEDCB. Each appears 1 cycle after accept.
- Exhaustive AND sweep: a=0..255, b=0x00FF, op=000, out_ready=1 -> out equals a&b every cycle, in_ready constantly 1, 256 results with no gaps.
- OR-reduce burst of 3 beats (op=110):
  - Beats: (0x0001,0x0000), (0x0000,0x0010), (0x0100,0x0000, last=1).
  - Required: busy=1 during the burst; a single output 0x0111 with count 3.
  - No output on the first two beats.
- Backpressure: hold out_ready=0 with a result pending.
  - Required: in_ready=0; out_data/out_count held stable over 5 cycles.
  - Then raise out_ready together with a new in_valid: new result follows next cycle with no bubble.
- Reset mid-burst: start a 110 burst of 2 beats, assert rst_n=0 between edges.
  - Required: out_valid, busy and out_count are 0 immediately.
  - Next single-beat 101 burst, a=0xFFFF b=0x0F0F last=1 -> 0x0F0F, count 1.
- Count saturation with CNT_W=2: XOR-reduce 5 beats of (0x0001,0x0000) -> out_data=0x0001, out_count=3.
